// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle CPU control FSM.
// Holds state encoding, opcode/funct values, ULA codes and mux selects.
// Also provides the per-state control decode used by the FSM.
package mc_ctrl_pkg;

  // FSM states; FETCH0 must stay at 0 because it is the reset/debug origin
  typedef enum logic [3:0] {
    S_FETCH0 = 4'd0,
    S_FETCH1 = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD0 = 4'd4,
    S_MEMRD1 = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_EXEC   = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_JUMP   = 4'd13
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ULAControl codes
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b111;

  // ULASrcB selects
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  // PCSrc selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control bundle, one value per state
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic [2:0] ula_ctrl;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       done;
  } ctrl_t;

  // Control values for a state; anything not set keeps the FETCH0 value.
  // exec_ula is only consulted in EXEC (R-type operation).
  function automatic ctrl_t state_ctrl(input state_t s, input logic [2:0] exec_ula);
    ctrl_t c;
    c           = '0;
    c.ula_ctrl  = ULA_ADD;
    c.ula_src_b = SRCB_ONE;
    c.pc_src    = PCSRC_ALU;
    case (s)
      S_FETCH1: begin
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
      end
      S_MEMADR: begin
        c.ula_src_a = 1'b1;
        c.ula_src_b = SRCB_IMM;
      end
      S_MEMRD0, S_MEMRD1: begin
        c.iord = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_dst    = 1'b1;
        c.done       = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
        c.done      = 1'b1;
      end
      S_EXEC: begin
        c.ula_src_a = 1'b1;
        c.ula_src_b = SRCB_REG;
        c.ula_ctrl  = exec_ula;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      S_BRANCH: begin
        c.ula_src_a = 1'b1;
        c.ula_src_b = SRCB_REG;
        c.ula_ctrl  = ULA_SUB;
        c.branch    = 1'b1;
        c.pc_src    = PCSRC_ALUOUT;
        c.done      = 1'b1;
      end
      S_ADDIEX: begin
        c.ula_src_a = 1'b1;
        c.ula_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.done      = 1'b1;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCSRC_JUMP;
        c.done     = 1'b1;
      end
      default: begin
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_ula_funct_dec.sv
// R-type Funct to ULAControl decoder with a valid flag for unknown functs.
// Latency: combinational.
// Backpressure: none; pure decode.
module ula_funct_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_ula_ctrl,
  output logic       o_valid
);

  // Map supported functs; anything else is flagged invalid
  always_comb begin
    o_ula_ctrl = ULA_ADD;
    o_valid    = 1'b1;
    case (i_funct)
      FN_ADD:  o_ula_ctrl = ULA_ADD;
      FN_SUB:  o_ula_ctrl = ULA_SUB;
      FN_AND:  o_ula_ctrl = ULA_AND;
      FN_OR:   o_ula_ctrl = ULA_OR;
      FN_SLT:  o_ula_ctrl = ULA_SLT;
      default: o_valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM sequencing the 8-bit multicycle CPU datapath.
// Latency: lw 7 cycles; sw/R-type/addi 5; beq/j 4; outputs follow the state register.
// Backpressure: step_en=0 freezes state and counter and forces every write-enable low.
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ULAControl,
  output logic             ULASrcA,
  output logic [1:0]       ULASrcB,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state_dbg
);

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_next_state;
  logic [2:0]       w_funct_ctrl;
  logic             w_funct_vld;
  logic             w_op_legal;

  ula_funct_dec u_ula_funct_dec (
    .i_funct    (Funct),
    .o_ula_ctrl (w_funct_ctrl),
    .o_valid    (w_funct_vld)
  );

  // Opcode legality; R-type additionally needs a known Funct
  always_comb begin
    w_op_legal = 1'b0;
    case (Op)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_op_legal = 1'b1;
      OP_RTYPE:                            w_op_legal = w_funct_vld;
      default:                             w_op_legal = 1'b0;
    endcase
  end

  // Next-state selection from the current state and instruction fields
  always_comb begin
    w_next_state = S_FETCH0;
    case (r_state)
      S_FETCH0: w_next_state = S_FETCH1;
      S_FETCH1: w_next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = w_funct_vld ? S_EXEC : S_FETCH0;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_FETCH0;
        endcase
      end
      S_MEMADR: w_next_state = (Op == OP_SW) ? S_MEMWR : S_MEMRD0;
      S_MEMRD0: w_next_state = S_MEMRD1;
      S_MEMRD1: w_next_state = S_MEMWB;
      S_EXEC:   w_next_state = S_ALUWB;
      S_ADDIEX: w_next_state = S_ADDIWB;
      default:  w_next_state = S_FETCH0;
    endcase
  end

  // State, registered control bundle for that state, and retired counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH0;
      r_ctrl  <= state_ctrl(S_FETCH0, ULA_ADD);
      r_cnt   <= '0;
    end else if (step_en) begin
      r_state <= w_next_state;
      r_ctrl  <= state_ctrl(w_next_state, w_funct_ctrl);
      if (r_ctrl.done) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Selects come straight from the registered bundle
  assign IorD       = r_ctrl.iord;
  assign PCSrc      = r_ctrl.pc_src;
  assign ULAControl = r_ctrl.ula_ctrl;
  assign ULASrcA    = r_ctrl.ula_src_a;
  assign ULASrcB    = r_ctrl.ula_src_b;
  assign MemtoReg   = r_ctrl.mem_to_reg;
  assign RegDst     = r_ctrl.reg_dst;

  // Enables and pulses are gated so a frozen cycle never writes anything
  assign MemWrite   = r_ctrl.mem_write & step_en;
  assign IRWrite    = r_ctrl.ir_write  & step_en;
  assign PCWrite    = r_ctrl.pc_write  & step_en;
  assign Branch     = r_ctrl.branch    & step_en;
  assign RegWrite   = r_ctrl.reg_write & step_en;
  assign instr_done = r_ctrl.done      & step_en;
  assign illegal    = (r_state == S_DECODE) & ~w_op_legal & step_en;

  assign instr_cnt  = r_cnt;
  assign state_dbg  = r_state;

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Moore-style control state machine that sequences the 8-bit multicycle CPU datapath: register file, ULA, PC register, instruction register, synchronous instruction ROM and data RAM. It replaces the combinational decoder as the source of every datapath select and write-enable. It spreads each instruction over fetch, decode, execute, memory and writeback steps, and accounts for the one-cycle read latency of the synchronous memories. It also provides single-step gating, an illegal-opcode flag and a retired-instruction counter for board debug on LEDs and the LCD.

## Interface
Parameters:
- CNT_W, 8, width of retired-instruction counter

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  reset, synchronous, active-low
- step_en  in  1  1 = FSM may advance; 0 = freeze state, suppress all write-enables
- Op  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- IorD  out  1  memory address select: 0 = PC, 1 = ULAOut
- MemWrite  out  1  data RAM write enable
- IRWrite  out  1  instruction register load
- PCWrite  out  1  unconditional PC load
- Branch  out  1  conditional PC load, ANDed externally with Z
- PCSrc  out  2  next PC: 00 = ULAResult, 01 = ULAOut, 10 = IR[7:0]
- ULAControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- ULASrcA  out  1  0 = PC, 1 = rd1 register
- ULASrcB  out  2  00 = rd2 register, 01 = constant 1, 10/11 = IR[7:0]
- RegWrite  out  1  register file write enable
- MemtoReg  out  1  writeback: 0 = ULAOut, 1 = data register
- RegDst  out  1  write address: 0 = IR[15:11] (rd), 1 = IR[20:16] (rt)
- illegal  out  1  one-cycle pulse in DECODE for an unsupported Op/Funct
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- instr_cnt  out  CNT_W  retired instructions, wraps
- state_dbg  out  4  current state encoding

## Operation
States and transitions. Unless noted, each state advances on the next edge when step_en=1.
- FETCH0: IorD=0, no enables. Applies PC to the ROM. -> FETCH1
- FETCH1: IRWrite=1, PCWrite=1, ULASrcA=0, ULASrcB=01, ULAControl=010, PCSrc=00 (PC+1). -> DECODE
- DECODE: register operands latch into rd1/rd2. Transition by Op:
  - 100011 lw or 101011 sw -> MEMADR
  - 000000 R-type -> EXEC
  - 000100 beq -> BRANCH
  - 001000 addi -> ADDIEX
  - 000010 j -> JUMP
  - anything else: illegal=1, -> FETCH0
- MEMADR: ULASrcA=1, ULASrcB=10, ULAControl=010. lw -> MEMRD0; sw -> MEMWR
- MEMRD0: IorD=1, read latency cycle. -> MEMRD1
- MEMRD1: IorD=1, data register captures. -> MEMWB
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=1. -> FETCH0
- MEMWR: IorD=1, MemWrite=1. -> FETCH0
- EXEC: ULASrcA=1, ULASrcB=00, ULAControl from Funct:
  - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
  - Unknown Funct was already trapped as illegal in DECODE.
  - -> ALUWB
- ALUWB: RegWrite=1, MemtoReg=0, RegDst=0. -> FETCH0
- BRANCH: ULASrcA=1, ULASrcB=00, ULAControl=110, Branch=1, PCSrc=01. -> FETCH0
- ADDIEX: ULASrcA=1, ULASrcB=10, ULAControl=010. -> ADDIWB
- ADDIWB: RegWrite=1, MemtoReg=0, RegDst=1. -> FETCH0
- JUMP: PCWrite=1, PCSrc=10. -> FETCH0

Output and counter rules:
- In any state not listed above, a select not mentioned takes its FETCH0 value and an enable not mentioned is 0.
- instr_done=1 in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP. instr_cnt increments by 1 on each such cycle and wraps from 2^CNT_W-1 to 0.

## Timing
- Outputs decode from the registered state only. The single exception is the gating of IRWrite, PCWrite, Branch, RegWrite, MemWrite, instr_done and illegal with step_en.
- Latency in cycles: lw 7; sw, R-type, addi 5; beq, j 4.
- step_en=0: state, instr_cnt and all selects hold, and every write-enable is 0. When step_en returns to 1, the held state executes in full on that cycle.
- Reset: rst=0 sampled on an edge puts the FSM in FETCH0 and sets instr_cnt=0, including mid-instruction, with no partial writeback afterwards.
  - While reset is held, outputs show FETCH0 values: all enables 0, IorD=0, ULASrcA=0, ULASrcB=01, ULAControl=010, PCSrc=00, RegDst=0, MemtoReg=0, illegal=0, instr_done=0, state_dbg=0.
- The illegal pulse does not count as a retired instruction.

## Structure
- Package mc_ctrl_pkg holds:
  - state enum (4-bit, FETCH0=0)
  - Op and Funct localparams
  - ULAControl codes
  - ULASrcB and PCSrc encodings
- Sub-module ula_funct_dec: combinational Funct -> ULAControl plus a valid bit. The FSM uses the valid bit for the illegal check in DECODE.

## Test plan
- Reset then step_en=1 with IR held at add (Op=000000, Funct=100000): state sequence FETCH0, FETCH1, DECODE, EXEC, ALUWB, FETCH0. ULAControl=010 in EXEC, RegWrite=1 with RegDst=0 in ALUWB, instr_cnt=1.
- lw (Op=100011): 7 cycles; IorD=1 in MEMRD0 and MEMRD1; MEMWB has RegWrite=1, MemtoReg=1, RegDst=1. sw: MemWrite=1 for exactly one cycle in MEMWR.
- beq, then j: BRANCH shows Branch=1, ULAControl=110, PCSrc=01. JUMP shows PCWrite=1, PCSrc=10. Both return to FETCH0 after 4 cycles.
- Op=111111: illegal=1 for one cycle in DECODE, next state FETCH0, instr_cnt unchanged.
- step_en=0 while in MEMWR for 3 cycles: MemWrite=0 and state held; then step_en=1 gives exactly one MemWrite pulse. Separately, rst=0 in MEMRD1 gives FETCH0 next, no RegWrite, and instr_cnt=0.
- 256 consecutive addi instructions: instr_cnt wraps 0xFF -> 0x00.
